// File: rtl/interp_feed_ctrl.sv
// interp_feed_ctrl: sample feed from an upstream stream to the interpolator.
// Optional: UNDERFLOW_RAMP_EN decays v_out toward 0 on underflow pops.
module interp_feed_ctrl (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable,
  input  logic [13:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  output logic [13:0] v_out,
  output logic        sample_strobe,
  output logic [3:0]  phase,
  output logic        underflow,
  output logic [15:0] underflow_cnt,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    MUTE  = 2'd3
  } state_t;

  localparam logic [3:0] POP_PH = 4'd14;
  localparam logic [3:0] STB_PH = 4'd15;

  state_t      state_q;
  state_t      state_d;
  logic [13:0] mem [4];
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic [2:0]  count;
  logic        pop_cyc;
  logic        push;
  logic        pop;
  logic        flush;
  logic        unf;
  logic        zero_v;

  assign pop_cyc       = (phase == POP_PH);
  assign sample_strobe = (phase == STB_PH);
  assign state         = state_q;
  assign underflow     = unf;

  // Ready only while collecting, judged from the registered fill level.
  assign s_ready = ((state_q == PRIME) || (state_q == RUN))
                && (count < 3'd4);

  assign push = s_valid && s_ready;

  // Free-running prescale phase, aligned with the interpolator by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      phase <= 4'd0;
    end else begin
      phase <= phase + 4'd1;
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state plus pop / flush / mute / underflow decisions.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    flush   = 1'b0;
    unf     = 1'b0;
    zero_v  = 1'b0;
    unique case (state_q)
      IDLE: begin
        flush = 1'b1;
        if (enable) begin
          state_d = PRIME;
        end
      end
      PRIME: begin
        if (!enable) begin
          state_d = MUTE;
        end else if (pop_cyc && (count >= 3'd2)) begin
          state_d = RUN;
          pop     = 1'b1;
        end
      end
      RUN: begin
        if (!enable) begin
          state_d = MUTE;
        end else if (pop_cyc) begin
          if (count == 3'd0) begin
            unf = 1'b1;
          end else begin
            pop = 1'b1;
          end
        end
      end
      MUTE: begin
        if (pop_cyc) begin
          flush   = 1'b1;
          zero_v  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sample storage; pointers and level decide what is valid.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  // FIFO pointers and fill level; a flush or reset drops every entry.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= 2'd0;
      wr_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      count <= count + {2'd0, push} - {2'd0, pop};
    end
  end

  // Output sample: loaded on the pop cycle so it is stable at phase 15.
  always_ff @(posedge clock) begin
    if (reset) begin
      v_out <= 14'd0;
    end else if (zero_v) begin
      v_out <= 14'd0;
    end else if (pop) begin
      v_out <= mem[rd_ptr];
    end else if (unf) begin
`ifdef UNDERFLOW_RAMP_EN
      v_out <= 14'($signed(v_out) >>> 1);
`else
      v_out <= v_out;
`endif
    end
  end

  // Saturating count of pops that found the FIFO empty.
  always_ff @(posedge clock) begin
    if (reset) begin
      underflow_cnt <= 16'd0;
    end else if (unf && (underflow_cnt != 16'hFFFF)) begin
      underflow_cnt <= underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_interp_feed_ctrl.sv
// tb_interp_feed_ctrl: directed bench with a scoreboard of expected samples.
// Expected v_out values queue on acceptance and dequeue on each pop.
module tb_interp_feed_ctrl;

  logic        clock;
  logic        reset;
  logic        enable;
  logic [13:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [13:0] v_out;
  logic        sample_strobe;
  logic [3:0]  phase;
  logic        underflow;
  logic [15:0] underflow_cnt;
  logic [1:0]  state;

  int          checks;
  int          failures;
  logic [3:0]  ph;
  int          cnt;
  logic [13:0] sb [$];

  interp_feed_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .v_out        (v_out),
    .sample_strobe(sample_strobe),
    .phase        (phase),
    .underflow    (underflow),
    .underflow_cnt(underflow_cnt),
    .state        (state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic r;
    r = reset;
    @(posedge clock);
    #1;
    ph = r ? 4'd0 : ph + 4'd1;
  endtask

  task automatic goto_ph(input logic [3:0] p);
    for (int i = 0; i < 17 && ph != p; i++) tick();
  endtask

  task automatic expect_pop(input string tag);
    logic [13:0] e;
    e = 'x;
    if (sb.size() > 0) e = sb.pop_front();
    check(tag, v_out, e);
    check({tag, "_stb"}, sample_strobe, 1'b1);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_phase"}, phase, 4'd0);
    check({tag, "_state"}, state, 2'd0);
    check({tag, "_vout"}, v_out, 14'd0);
    check({tag, "_ready"}, s_ready, 1'b0);
    check({tag, "_unf"}, underflow, 1'b0);
    check({tag, "_unfcnt"}, underflow_cnt, 16'd0);
  endtask

  initial begin
    int          nxt;
    int          pops;
    int          cyc;
    bit          acc;
    bit          popnow;
    bit          saw_full;
    logic [13:0] expv;

    checks   = 0;
    failures = 0;
    ph       = 4'd0;
    cnt      = 0;
    reset    = 1'b1;
    enable   = 1'b0;
    s_valid  = 1'b0;
    s_data   = 14'd0;

    tick();
    reset = 1'b0;
    check_reset_outs("rst");

    for (int i = 0; i < 40; i++) begin
      tick();
      check("idle_phase", phase, ph);
      check("idle_stb", sample_strobe, ph == 4'd15);
    end
    check("idle_state", state, 2'd0);
    check("idle_vout", v_out, 14'd0);
    check("idle_ready", s_ready, 1'b0);

    enable = 1'b1;
    tick();
    check("prime_state", state, 2'd1);
    check("prime_ready", s_ready, 1'b1);
    s_valid = 1'b1;
    s_data  = 14'd100;
    tick();
    sb.push_back(14'd100);
    s_data = 14'd200;
    check("prime_ready2", s_ready, 1'b1);
    tick();
    sb.push_back(14'd200);
    s_valid = 1'b0;
    cnt     = 2;
    goto_ph(4'd14);
    check("prime_wait", state, 2'd1);
    tick();
    cnt = 1;
    check("run_enter", state, 2'd2);
    expect_pop("pop100");
    goto_ph(4'd14);
    check("pop200_unf", underflow, 1'b0);
    tick();
    cnt = 0;
    expect_pop("pop200");

    nxt      = 0;
    pops     = 0;
    cyc      = 0;
    saw_full = 1'b0;
    s_valid  = 1'b1;
    s_data   = 14'd0;
    while (pops < 64 && cyc < 1200) begin
      acc    = (nxt < 64) && s_ready;
      popnow = (ph == 4'd14) && (cnt > 0);
      check("ramp_ready", s_ready, cnt < 4);
      check("ramp_unf", underflow, (ph == 4'd14) && (cnt == 0));
      if (!s_ready) saw_full = 1'b1;
      tick();
      if (acc) begin
        sb.push_back(nxt[13:0]);
        nxt++;
        cnt++;
      end
      if (popnow) begin
        cnt--;
        expect_pop("ramp_pop");
        pops++;
      end
      s_valid = (nxt < 64);
      s_data  = nxt[13:0];
      cyc++;
    end
    s_valid = 1'b0;
    check("ramp_pops", pops, 64);
    check("ramp_full_seen", saw_full, 1'b1);

    s_valid = 1'b1;
    s_data  = 14'd1000;
    check("u_ready", s_ready, 1'b1);
    tick();
    sb.push_back(14'd1000);
    s_valid = 1'b0;
    goto_ph(4'd14);
    check("u_pre_unf", underflow, 1'b0);
    tick();
    expect_pop("pop1000");
    expv = 14'd1000;
    for (int k = 1; k <= 3; k++) begin
      goto_ph(4'd14);
      check("u_pulse", underflow, 1'b1);
      tick();
`ifdef UNDERFLOW_RAMP_EN
      expv = 14'($signed(expv) >>> 1);
`endif
      check("u_pulse_end", underflow, 1'b0);
      check("u_cnt", underflow_cnt, k);
      check("u_vout", v_out, expv);
      check("u_state", state, 2'd2);
    end

    s_valid = 1'b1;
    s_data  = 14'h2000;
    tick();
    sb.push_back(14'h2000);
    s_valid = 1'b0;
    goto_ph(4'd14);
    check("neg_unf", underflow, 1'b0);
    tick();
    expect_pop("pop_neg");
    s_valid = 1'b1;
    s_data  = 14'd11;
    tick();
    s_data = 14'd12;
    tick();
    s_valid = 1'b0;
    enable  = 1'b0;
    tick();
    check("mute_state", state, 2'd3);
    check("mute_ready", s_ready, 1'b0);
    check("mute_vout", v_out, 14'h2000);
    goto_ph(4'd14);
    check("mute_hold_state", state, 2'd3);
    check("mute_hold_vout", v_out, 14'h2000);
    check("mute_unf", underflow, 1'b0);
    tick();
    check("mute_zero", v_out, 14'd0);
    check("mute_idle", state, 2'd0);
    tick();
    check("idle2_state", state, 2'd0);
    check("idle2_ready", s_ready, 1'b0);

    enable = 1'b1;
    tick();
    check("prime2_state", state, 2'd1);
    for (int i = 0; i < 4; i++) begin
      check("fill_ready", s_ready, 1'b1);
      s_valid = 1'b1;
      s_data  = 14'(21 + i);
      tick();
      sb.push_back(14'(21 + i));
    end
    s_valid = 1'b0;
    check("fill_full", s_ready, 1'b0);
    goto_ph(4'd14);
    check("prime2_wait", state, 2'd1);
    tick();
    check("run2_state", state, 2'd2);
    expect_pop("pop21");
    goto_ph(4'd7);
    check("pre_rst_phase", phase, 4'd7);
    check("pre_rst_state", state, 2'd2);
    check("pre_rst_ready", s_ready, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_outs("mid_rst");
    sb.delete();
    tick();
    check("post_rst_prime", state, 2'd1);
    s_valid = 1'b1;
    s_data  = 14'd31;
    tick();
    sb.push_back(14'd31);
    s_data = 14'd32;
    tick();
    sb.push_back(14'd32);
    s_valid = 1'b0;
    goto_ph(4'd14);
    tick();
    check("run3_state", state, 2'd2);
    expect_pop("pop31");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/interp_feed_ctrl.md
INTERP_FEED_CTRL -- requirements
Module: interp_feed_ctrl

Interface
REQ-001 SHALL have port clock  input  1  single system clock (4 GHz modulator clock domain), all logic on its rising edge.
REQ-002 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-003 SHALL have port enable  input  1  level; 1 = stream samples to interpolator, 0 = stop and mute.
REQ-004 SHALL have port s_data  input  14  upstream signed sample (two's complement).
REQ-005 SHALL have port s_valid  input  1  upstream sample valid.
REQ-006 SHALL have port s_ready  output  1  block accepts s_data this cycle; transfer = s_valid && s_ready.
REQ-007 SHALL have port v_out  output  14  registered sample driven to interpolator v_in.
REQ-008 SHALL have port sample_strobe  output  1  high when phase == 15, i.e. the cycle the interpolator latches v_out.
REQ-009 SHALL have port phase  output  4  free-running prescale phase counter.
REQ-010 SHALL have port underflow  output  1  one-cycle pulse when a scheduled pop finds the FIFO empty.
REQ-011 SHALL have port underflow_cnt  output  16  saturating underflow event count.
REQ-012 SHALL have port state  output  2  FSM state: 0 IDLE, 1 PRIME, 2 RUN, 3 MUTE.

Function
REQ-013 SHALL increment phase by 1 every cycle, wrapping 15 -> 0, independent of enable and state.
REQ-014 SHALL hold a 4-entry FIFO of 14-bit samples with count 0..4; s_ready = (state is PRIME or RUN) && count < 4, from registered count only.
REQ-015 SHALL on a pop cycle (phase == 14, RUN) load v_out from the FIFO head, so v_out is stable during phase 15; simultaneous push and pop SHALL leave count unchanged and preserve order.
REQ-016 IDLE: v_out = 0, FIFO flushed; enable = 1 -> PRIME next cycle.
REQ-017 PRIME: accept samples; at phase == 14 with count >= 2 -> RUN and perform the first pop that same cycle; enable = 0 -> MUTE.
REQ-018 RUN: pop at every phase == 14; if count == 0 at that cycle, v_out holds its value, underflow pulses for that cycle, underflow_cnt increments (saturating at 16'hFFFF), state stays RUN.
REQ-019 RUN: enable = 0 -> MUTE; no further pops; s_ready = 0.
REQ-020 MUTE: at next phase == 14, v_out <= 0 and FIFO is flushed; next cycle -> IDLE.
REQ-021 Whenever phase == 14 and the FSM is in IDLE, MUTE, or PRIME without a pop, v_out SHALL be unchanged, apart from the MUTE zeroing in REQ-020.
REQ-022 Latency: a sample accepted at least 1 cycle before a pop cycle, with the FIFO otherwise empty in RUN, SHALL appear on v_out on that pop cycle's next edge.

Reset
REQ-023 On reset: phase = 0, state = IDLE, count = 0, v_out = 0, underflow = 0, underflow_cnt = 0, s_ready = 0; reset SHALL be shared with the interpolator so phase aligns with its prescale counter.
REQ-024 Reset asserted mid-RUN SHALL discard FIFO contents and take effect on the next edge, overriding all other events.

Configuration
REQ-025 Macro UNDERFLOW_RAMP_EN: when defined, an underflow pop SHALL load v_out with v_out arithmetically shifted right by 1 (decay toward 0, -1 stays -1) instead of holding; when undefined, v_out holds (REQ-018).

Verification
REQ-026 Reset then 40 cycles with enable = 0 -> phase wraps 15 -> 0, state = 0, v_out = 0, s_ready = 0.
REQ-027 enable = 1, push 100 and 200 back-to-back -> RUN at the first phase 14 with count >= 2; v_out = 100, then v_out = 200 sixteen cycles later; sample_strobe high while each value is stable.
REQ-028 RUN with a continuous source -> s_ready drops when count = 4, and no sample is lost or reordered over 64 pops of a ramp 0..63.
REQ-029 RUN, source stalls after v_out = 1000 -> underflow pulses at each phase 14 and underflow_cnt counts 1, 2, 3; v_out = 1000, or 500, 250, 125 with UNDERFLOW_RAMP_EN.
REQ-030 enable = 0 in RUN with v_out = -8192 -> state = MUTE, v_out = 0 at the next phase 14, then IDLE with count = 0.
REQ-031 Reset asserted at phase 7 in RUN with count = 3 -> next cycle all outputs hold their reset values and phase = 0.
